// File: rtl/clic_pkg.sv
// rtl/clic_pkg.sv - shared trigger-encoding constants for the CLIC blocks
// Purpose : attr_trig field encodings shared by the gateway and the register adapter.
// Ports   : none (package).
package clic_pkg;

   localparam logic TRIG_LEVEL   = 1'b0;   // attr_trig[0] value for level-sensitive
   localparam logic TRIG_EDGE    = 1'b1;   // attr_trig[0] value for edge-triggered
   localparam int   TRIG_POL_BIT = 1;      // attr_trig bit selecting active-low / falling edge

endpackage

// File: rtl/clic_sync.sv
// rtl/clic_sync.sv - N-stage reset-to-0 single-bit synchroniser
// Purpose : brings one possibly asynchronous line into the clk_i domain.
// Ports   : clk_i, rst_ni (async active-low), d_i raw line, q_o synchronised line.
//           STAGES must be >= 1; the zero-stage bypass lives in the instantiating block.
module clic_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] ff_q, ff_d;

   always_comb begin
      ff_d    = ff_q;
      ff_d[0] = d_i;
      for (int k = 1; k < STAGES; k++) begin
         ff_d[k] = ff_q[k-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ff_q <= '0;
      end else begin
         ff_q <= ff_d;
      end
   end

   assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/clic_gateway.sv
// rtl/clic_gateway.sv - per-source CLIC interrupt gateway producing pending bits
// Purpose : synchronises interrupt lines, applies polarity, latches edge events
//           until claimed or software-cleared, and follows lines in level mode.
// Ports   : clk_i, rst_ni (async active-low)
//           intr_src_i  raw interrupt lines
//           le_i/pol_i  per-source trigger type / polarity
//           sw_set_i/sw_clr_i  one-cycle software set / clear pulses
//           claim_valid_i/claim_id_i  claim from the core
//           claim_ack_o/claim_edge_o  registered claim response
//           ip_o        registered pending bits
module clic_gateway
   import clic_pkg::*;
#(
   parameter int N_SOURCE    = 32,
   parameter int SYNC_STAGES = 2,
   parameter int IDW         = $clog2(N_SOURCE)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_SOURCE-1:0] intr_src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [N_SOURCE-1:0] pol_i,
   input  logic [N_SOURCE-1:0] sw_set_i,
   input  logic [N_SOURCE-1:0] sw_clr_i,
   input  logic                claim_valid_i,
   input  logic [IDW-1:0]      claim_id_i,
   output logic                claim_ack_o,
   output logic                claim_edge_o,
   output logic [N_SOURCE-1:0] ip_o
);

   logic [N_SOURCE-1:0] s;
   logic [N_SOURCE-1:0] p_q, p_d;     // previous synchronised value (pre-polarity)
   logic [N_SOURCE-1:0] ip_q, ip_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                armed_q, armed_d;
   logic                ack_q, ack_d;
   logic                cedge_q, cedge_d;

   logic [N_SOURCE-1:0] edge_m, a, pa, e, clm, clr;

   for (genvar gi = 0; gi < N_SOURCE; gi++) begin : g_src
      if (SYNC_STAGES == 0) begin : g_bypass
         assign s[gi] = intr_src_i[gi];
      end else begin : g_sync
         clic_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (intr_src_i[gi]),
            .q_o   (s[gi])
         );
      end
   end

   always_comb begin
      edge_m = le_i ~^ {N_SOURCE{TRIG_EDGE}};
      a      = s ^ pol_i;
      // Polarity is applied to the stored value with the current pol_i, so a
      // polarity change flips both sides of the compare and never fakes an edge.
      pa     = p_q ^ pol_i;
      e      = {N_SOURCE{armed_q}} & a & ~pa;
      clm    = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         clm[i] = claim_valid_i && (claim_id_i == IDW'(i));
      end
      clr    = sw_clr_i | clm;
      // Set terms are ORed after the clear mask, so a new event wins over a clear.
      ip_d   = (edge_m & (e | sw_set_i | (ip_q & ~clr))) | (~edge_m & a);
      p_d    = s;

      // Out-of-range IDs match no bit of clm, so they ack with edge=0 and change nothing.
      ack_d   = claim_valid_i;
      cedge_d = |(clm & edge_m & ip_q);

      // Warm-up: the reset-zero synchroniser/p flops would otherwise show a
      // rising active value on lines that idle active.
      armed_d = armed_q | (cnt_q == 2'(SYNC_STAGES));
      cnt_d   = armed_q ? cnt_q : cnt_q + 2'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_q     <= '0;
         ip_q    <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         ack_q   <= 1'b0;
         cedge_q <= 1'b0;
      end else begin
         p_q     <= p_d;
         ip_q    <= ip_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         ack_q   <= ack_d;
         cedge_q <= cedge_d;
      end
   end

   assign ip_o         = ip_q;
   assign claim_ack_o  = ack_q;
   assign claim_edge_o = cedge_q;

endmodule

// File: tb/tb_clic_gateway.sv
// tb/tb_clic_gateway.sv - self-checking bench for clic_gateway
module tb_clic_gateway;

   localparam int N    = 20;
   localparam int SYNC = 2;
   localparam int IDW  = 5;

   logic           clk = 1'b0;
   logic           rst_ni;
   logic [N-1:0]   intr_src, le, pol, sw_set, sw_clr;
   logic           claim_valid;
   logic [IDW-1:0] claim_id;
   logic           claim_ack, claim_edge;
   logic [N-1:0]   ip;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   clic_gateway #(.N_SOURCE(N), .SYNC_STAGES(SYNC), .IDW(IDW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .intr_src_i   (intr_src),
      .le_i         (le),
      .pol_i        (pol),
      .sw_set_i     (sw_set),
      .sw_clr_i     (sw_clr),
      .claim_valid_i(claim_valid),
      .claim_id_i   (claim_id),
      .claim_ack_o  (claim_ack),
      .claim_edge_o (claim_edge),
      .ip_o         (ip)
   );

   // Reference model: the line seen by the gateway is the raw line as sampled
   // SYNC clock edges earlier; an edge is a rise of the active value once more
   // than SYNC edges have elapsed since reset.
   logic [N-1:0] hist[$];
   int           n_edges;
   logic [N-1:0] m_prev_s, m_ip;
   logic         m_ack, m_edge;

   function automatic void model_reset();
      hist.delete();
      n_edges  = 0;
      m_prev_s = '0;
      m_ip     = '0;
      m_ack    = 1'b0;
      m_edge   = 1'b0;
   endfunction

   function automatic void model_edge();
      logic [N-1:0] s_cur, nxt;
      logic         armed, rise, claimed;
      if (SYNC == 0)                 s_cur = intr_src;
      else if (hist.size() >= SYNC)  s_cur = hist[hist.size()-SYNC];
      else                           s_cur = '0;
      armed  = (n_edges >= SYNC + 1);
      m_ack  = claim_valid;
      m_edge = 1'b0;
      if (claim_valid && int'(claim_id) < N)
         m_edge = le[claim_id] & m_ip[claim_id];
      for (int i = 0; i < N; i++) begin
         if (!le[i]) begin
            nxt[i] = s_cur[i] ^ pol[i];
         end else begin
            rise    = armed && (s_cur[i] ^ pol[i]) && !(m_prev_s[i] ^ pol[i]);
            claimed = claim_valid && (int'(claim_id) == i);
            nxt[i]  = rise || sw_set[i] || (m_ip[i] && !(sw_clr[i] || claimed));
         end
      end
      m_ip     = nxt;
      m_prev_s = s_cur;
      hist.push_back(intr_src);
      if (hist.size() > SYNC + 1) void'(hist.pop_front());
      if (n_edges < 1000) n_edges++;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check("mdl_ip",   32'(ip),    32'(m_ip));
      check("mdl_ack",  32'(claim_ack),  32'(m_ack));
      check("mdl_edge", 32'(claim_edge), 32'(m_edge));
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      sw_set = '0; sw_clr = '0; claim_valid = 1'b0; claim_id = '0;
      rst_ni = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_ip",   32'(ip), 32'h0);
      check("rst_ack",  32'(claim_ack), 32'h0);
      check("rst_edge", 32'(claim_edge), 32'h0);
      rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic claim(input int id);
      claim_valid = 1'b1;
      claim_id    = IDW'(id);
      tick();
      claim_valid = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0]   set;
      logic [N-1:0]   clr;
      logic           cv;
      logic [IDW-1:0] cid;
      logic [N-1:0]   eip;
      logic           eack;
      logic           eedge;
   } vec_t;

   vec_t tbl[12];

   initial begin
      intr_src = '0; le = '0; pol = '0; sw_set = '0; sw_clr = '0;
      claim_valid = 1'b0; claim_id = '0; rst_ni = 1'b0;
      model_reset();

      // Lines idling active from reset must not produce an edge.
      le = '1;
      pol[9] = 1'b1;
      intr_src[10] = 1'b1;
      do_reset();
      ticks(10);
      check("idle_active_ip", 32'(ip), 32'h0);
      intr_src[10] = 1'b0;
      pol[9] = 1'b0;
      ticks(4);
      check("pol_change_ip", 32'(ip), 32'h0);

      // Software / claim table in edge mode with all lines quiet.
      tbl[0]  = '{set:20'h00021, clr:20'h0,     cv:0, cid:5'd0,  eip:20'h00021, eack:0, eedge:0};
      tbl[1]  = '{set:20'h0,     clr:20'h0,     cv:0, cid:5'd0,  eip:20'h00021, eack:0, eedge:0};
      tbl[2]  = '{set:20'h0,     clr:20'h0,     cv:1, cid:5'd5,  eip:20'h00001, eack:1, eedge:1};
      tbl[3]  = '{set:20'h0,     clr:20'h0,     cv:1, cid:5'd5,  eip:20'h00001, eack:1, eedge:0};
      tbl[4]  = '{set:20'h00080, clr:20'h00080, cv:0, cid:5'd0,  eip:20'h00081, eack:0, eedge:0};
      tbl[5]  = '{set:20'h0,     clr:20'h00001, cv:0, cid:5'd0,  eip:20'h00080, eack:0, eedge:0};
      tbl[6]  = '{set:20'h0,     clr:20'h0,     cv:1, cid:5'd20, eip:20'h00080, eack:1, eedge:0};
      tbl[7]  = '{set:20'h00080, clr:20'h0,     cv:1, cid:5'd7,  eip:20'h00080, eack:1, eedge:1};
      tbl[8]  = '{set:20'h0,     clr:20'h00080, cv:0, cid:5'd0,  eip:20'h00000, eack:0, eedge:0};
      tbl[9]  = '{set:20'hFFFFF, clr:20'h0,     cv:0, cid:5'd0,  eip:20'hFFFFF, eack:0, eedge:0};
      tbl[10] = '{set:20'h0,     clr:20'h0,     cv:1, cid:5'd19, eip:20'h7FFFF, eack:1, eedge:1};
      tbl[11] = '{set:20'h0,     clr:20'hFFFFF, cv:0, cid:5'd0,  eip:20'h00000, eack:0, eedge:0};
      for (int v = 0; v < 12; v++) begin
         sw_set = tbl[v].set; sw_clr = tbl[v].clr;
         claim_valid = tbl[v].cv; claim_id = tbl[v].cid;
         tick();
         sw_set = '0; sw_clr = '0; claim_valid = 1'b0;
         check($sformatf("tbl%0d_ip", v),   32'(ip),         32'(tbl[v].eip));
         check($sformatf("tbl%0d_ack", v),  32'(claim_ack),  32'(tbl[v].eack));
         check($sformatf("tbl%0d_edge", v), 32'(claim_edge), 32'(tbl[v].eedge));
      end

      // Edge detected in the same cycle as a claim of that source.
      sw_set[7] = 1'b1; tick(); sw_set = '0;
      intr_src[7] = 1'b1;
      ticks(2);
      claim(7);
      check("edge_vs_claim_ip7", 32'(ip[7]), 32'h1);
      check("edge_vs_claim_edge", 32'(claim_edge), 32'h1);
      claim(7);
      check("reclaim_ip7", 32'(ip[7]), 32'h0);
      intr_src[7] = 1'b0;
      ticks(3);

      // Two-cycle pulse latched, then claimed.
      intr_src[5] = 1'b1; ticks(2);
      intr_src[5] = 1'b0; ticks(4);
      check("pulse_hold_ip5", 32'(ip[5]), 32'h1);
      claim(5);
      check("claim5_ip5", 32'(ip[5]), 32'h0);
      check("claim5_ack", 32'(claim_ack), 32'h1);
      check("claim5_edge", 32'(claim_edge), 32'h1);

      // Level mode, active high, three-edge latency both ways.
      le = '0;
      ticks(4);
      intr_src[3] = 1'b1;
      ticks(2);
      check("lvl_rise_early", 32'(ip[3]), 32'h0);
      tick();
      check("lvl_rise_ip3", 32'(ip[3]), 32'h1);
      claim(3);
      check("lvl_claim_ack", 32'(claim_ack), 32'h1);
      check("lvl_claim_edge", 32'(claim_edge), 32'h0);
      check("lvl_claim_ip3", 32'(ip[3]), 32'h1);
      intr_src[3] = 1'b0;
      ticks(2);
      check("lvl_fall_early", 32'(ip[3]), 32'h1);
      tick();
      check("lvl_fall_ip3", 32'(ip[3]), 32'h0);

      // Software pulses in level vs edge mode.
      sw_set[0] = 1'b1; tick(); sw_set = '0;
      check("lvl_swset_ip0", 32'(ip[0]), 32'h0);
      sw_clr[0] = 1'b1; tick(); sw_clr = '0;
      check("lvl_swclr_ip0", 32'(ip[0]), 32'h0);
      le[0] = 1'b1;
      sw_set[0] = 1'b1; tick(); sw_set = '0;
      check("edg_swset_ip0", 32'(ip[0]), 32'h1);
      sw_clr[0] = 1'b1; tick(); sw_clr = '0;
      check("edg_swclr_ip0", 32'(ip[0]), 32'h0);

      // Asynchronous reset while everything is pending.
      le = '1;
      sw_set = '1; tick(); sw_set = '0;
      check("all_set_ip", 32'(ip), 32'hFFFFF);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_rst_ip", 32'(ip), 32'h0);
      do_reset();

      // Randomised run against the model.
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) intr_src[b] = ~intr_src[b];
         if ($urandom_range(0, 49) == 0) le  = N'($urandom);
         if ($urandom_range(0, 79) == 0) pol = N'($urandom);
         sw_set = N'($urandom & $urandom & $urandom);
         sw_clr = N'($urandom & $urandom & $urandom);
         claim_valid = ($urandom_range(0, 2) == 0);
         claim_id    = IDW'($urandom_range(0, 23));
         tick();
         if (c % 997 == 500) do_reset();
      end
      sw_set = '0; sw_clr = '0; claim_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
